// File: rtl/voting_pkg.sv
// Shared types and sizing helpers for the vote arbiter.
// VOTE_ARBITER_DUP_LOCK_EN (optional) enables the per-booth duplicate-vote lock in vote_arbiter.
package voting_pkg;

    typedef enum logic [1:0] {
        ST_CLOSED = 2'd0,
        ST_IDLE   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_RESP   = 2'd3
    } vote_state_t;

    localparam int DEF_NUM_BOOTHS     = 4;
    localparam int DEF_NUM_CANDIDATES = 4;
    localparam int DEF_CNT_W          = 8;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/vote_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module rr_arbiter #(
    parameter int WIDTH = 4,
    parameter int PTR_W = 2
) (
    input  logic [WIDTH-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [WIDTH-1:0] gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             any
);

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int off = 1; off <= WIDTH; off++) begin
            idx = (int'(ptr) + off) % WIDTH;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/vote_arbiter.sv
// Session controller and round-robin arbiter committing booth votes into shared tallies.
// Optional duplicate-vote lock is built when VOTE_ARBITER_DUP_LOCK_EN is defined.
module vote_arbiter
    import voting_pkg::*;
#(
    parameter int NUM_BOOTHS     = DEF_NUM_BOOTHS,
    parameter int NUM_CANDIDATES = DEF_NUM_CANDIDATES,
    parameter int CNT_W          = DEF_CNT_W,
    localparam int CAND_W        = clog2_min1(NUM_CANDIDATES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         session_open,
    input  logic                         session_close,
    input  logic [NUM_BOOTHS-1:0]        vote_req,
    input  logic [NUM_BOOTHS*CAND_W-1:0] vote_cand,
    output logic [NUM_BOOTHS-1:0]        vote_ack,
    output logic [NUM_BOOTHS-1:0]        vote_rej,
    output logic [NUM_BOOTHS-1:0]        grant,
    output logic                         session_active,
    output logic                         busy,
    input  logic [CAND_W-1:0]            rd_sel,
    output logic [CNT_W-1:0]             rd_tally,
    output logic [CNT_W-1:0]             total_votes
);

    localparam int PTR_W      = clog2_min1(NUM_BOOTHS);
    localparam int CAND_SLOTS = 1 << CAND_W;

    vote_state_t             state;
    logic [PTR_W-1:0]        ptr;
    logic [PTR_W-1:0]        grant_idx;
    logic                    close_pend;
    logic [CNT_W-1:0]        tally [CAND_SLOTS];

    logic [NUM_BOOTHS-1:0]   arb_gnt;
    logic [PTR_W-1:0]        arb_idx;
    logic                    arb_any;

    logic [CAND_W-1:0]       cand_sel;
    logic                    cand_valid;
    logic                    dup_block;
    logic                    accept;
    logic                    rd_valid;

    rr_arbiter #(
        .WIDTH (NUM_BOOTHS),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req     (vote_req),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

`ifdef VOTE_ARBITER_DUP_LOCK_EN
    logic [NUM_BOOTHS-1:0] voted;
    assign dup_block = voted[grant_idx];
`else
    assign dup_block = 1'b0;
`endif

    always_comb begin
        cand_sel   = vote_cand[int'(grant_idx)*CAND_W +: CAND_W];
        cand_valid = ({1'b0, cand_sel} < (CAND_W+1)'(NUM_CANDIDATES));
        accept     = cand_valid && !dup_block;
    end

    always_comb begin
        rd_valid = ({1'b0, rd_sel} < (CAND_W+1)'(NUM_CANDIDATES));
        rd_tally = rd_valid ? tally[rd_sel] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_CLOSED;
            ptr            <= PTR_W'(NUM_BOOTHS - 1);
            grant_idx      <= '0;
            grant          <= '0;
            vote_ack       <= '0;
            vote_rej       <= '0;
            session_active <= 1'b0;
            busy           <= 1'b0;
            close_pend     <= 1'b0;
            total_votes    <= '0;
            for (int i = 0; i < CAND_SLOTS; i++) tally[i] <= '0;
`ifdef VOTE_ARBITER_DUP_LOCK_EN
            voted          <= '0;
`endif
        end else begin
            // ack/rej are single-cycle pulses: set in COMMIT, visible only in RESP.
            vote_ack <= '0;
            vote_rej <= '0;
            case (state)
                ST_CLOSED: begin
                    if (session_open && !session_close) begin
                        state          <= ST_IDLE;
                        session_active <= 1'b1;
                        close_pend     <= 1'b0;
                        total_votes    <= '0;
                        for (int i = 0; i < CAND_SLOTS; i++) tally[i] <= '0;
`ifdef VOTE_ARBITER_DUP_LOCK_EN
                        voted          <= '0;
`endif
                    end
                end
                ST_IDLE: begin
                    if (session_close) begin
                        state          <= ST_CLOSED;
                        session_active <= 1'b0;
                    end else if (arb_any) begin
                        state      <= ST_COMMIT;
                        grant      <= arb_gnt;
                        grant_idx  <= arb_idx;
                        ptr        <= arb_idx;
                        busy       <= 1'b1;
                        close_pend <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    if (session_close) close_pend <= 1'b1;
                    if (accept) begin
                        if (tally[cand_sel] != '1) tally[cand_sel] <= tally[cand_sel] + 1'b1;
                        if (total_votes != '1) total_votes <= total_votes + 1'b1;
                        vote_ack[grant_idx] <= 1'b1;
`ifdef VOTE_ARBITER_DUP_LOCK_EN
                        voted[grant_idx]    <= 1'b1;
`endif
                    end else begin
                        vote_rej[grant_idx] <= 1'b1;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    if (close_pend || session_close) begin
                        state          <= ST_CLOSED;
                        session_active <= 1'b0;
                        close_pend     <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_CLOSED;
            endcase
        end
    end

endmodule
